// File: rtl/qea_pkg.sv
// Shared types, widths and helpers for the QEA state-RAM unloader.
package qea_pkg;

    localparam int unsigned PE_NUM_WIDTH     = 2;
    localparam int unsigned PE_NUM           = 4;
    localparam int unsigned DATA_WIDTH       = 32;
    localparam int unsigned AMP_WIDTH        = 2 * DATA_WIDTH;
    localparam int unsigned STATE_DATA_WIDTH = AMP_WIDTH;
    localparam int unsigned STATE_ADDR_WIDTH = 16;
    localparam int unsigned MAX_QBIT_WIDTH   = 6;
    localparam int unsigned MAX_QBIT         = STATE_ADDR_WIDTH + PE_NUM_WIDTH;
    localparam int unsigned IDX_WIDTH        = MAX_QBIT;
    localparam int unsigned WORD_WIDTH       = PE_NUM * STATE_DATA_WIDTH;
    localparam int unsigned LAT_WIDTH        = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_EMIT,
        ST_DONE
    } state_e;

    // Clamp the requested qubit count into the range the state RAM can hold.
    function automatic logic [MAX_QBIT_WIDTH-1:0] eff_qbit(input logic [MAX_QBIT_WIDTH-1:0] qbit);
        if (qbit < MAX_QBIT_WIDTH'(PE_NUM_WIDTH)) return MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
        if (qbit > MAX_QBIT_WIDTH'(MAX_QBIT))     return MAX_QBIT_WIDTH'(MAX_QBIT);
        return qbit;
    endfunction

    // Number of state words holding 2^q amplitudes (q already clamped).
    function automatic logic [STATE_ADDR_WIDTH:0] word_count(input logic [MAX_QBIT_WIDTH-1:0] q);
        return (STATE_ADDR_WIDTH + 1)'(1) << (q - MAX_QBIT_WIDTH'(PE_NUM_WIDTH));
    endfunction

endpackage

// File: rtl/qea_word_serializer.sv
// Serializes one buffered state word onto the amplitude stream, MSB slice first.
module qea_word_serializer
    import qea_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic [WORD_WIDTH-1:0] i_word,
    input  logic [IDX_WIDTH-1:0]  i_base_idx,
    input  logic                  i_last_word,
    output logic                  o_amp_valid,
    input  logic                  i_amp_ready,
    output logic [AMP_WIDTH-1:0]  o_amp_data,
    output logic [IDX_WIDTH-1:0]  o_amp_idx,
    output logic                  o_amp_last,
    output logic                  o_drained_c
);

    logic [WORD_WIDTH-1:0]   buf_q, buf_d;
    logic [PE_NUM_WIDTH-1:0] slice_q, slice_d;
    logic                    last_word_q, last_word_d;
    logic                    valid_q, valid_d;
    logic [AMP_WIDTH-1:0]    data_q, data_d;
    logic [IDX_WIDTH-1:0]    idx_q, idx_d;
    logic                    last_q, last_d;
    logic [PE_NUM_WIDTH-1:0] nslice;
    logic                    xfer;

    // Next beat: load a fresh word, or step to the next slice on a handshake.
    always_comb begin
        buf_d       = buf_q;
        slice_d     = slice_q;
        last_word_d = last_word_q;
        valid_d     = valid_q;
        data_d      = data_q;
        idx_d       = idx_q;
        last_d      = last_q;
        xfer        = valid_q & i_amp_ready;
        nslice      = slice_q - PE_NUM_WIDTH'(1);
        o_drained_c = xfer && (slice_q == PE_NUM_WIDTH'(0));

        if (i_load) begin
            buf_d       = i_word;
            slice_d     = PE_NUM_WIDTH'(PE_NUM - 1);
            last_word_d = i_last_word;
            valid_d     = 1'b1;
            data_d      = i_word[(PE_NUM-1)*AMP_WIDTH +: AMP_WIDTH];
            idx_d       = i_base_idx;
            last_d      = i_last_word && (PE_NUM == 1);
        end else if (xfer) begin
            if (slice_q == PE_NUM_WIDTH'(0)) begin
                valid_d = 1'b0;
                last_d  = 1'b0;
            end else begin
                slice_d = nslice;
                data_d  = buf_q[32'(nslice) * AMP_WIDTH +: AMP_WIDTH];
                idx_d   = idx_q + IDX_WIDTH'(1);
                last_d  = last_word_q && (nslice == PE_NUM_WIDTH'(0));
            end
        end
    end

    // Beat registers; outputs held stable until the handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_q       <= '0;
            slice_q     <= '0;
            last_word_q <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            idx_q       <= '0;
            last_q      <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            slice_q     <= slice_d;
            last_word_q <= last_word_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
        end
    end

    assign o_amp_valid = valid_q;
    assign o_amp_data  = data_q;
    assign o_amp_idx   = idx_q;
    assign o_amp_last  = last_q;

endmodule

// File: rtl/qea_state_unloader.sv
// Walks the QEA state RAM and streams every amplitude out in index order.
module qea_state_unloader
    import qea_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_start,
    input  logic [MAX_QBIT_WIDTH-1:0]   i_qbit_num,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [PE_NUM-1:0]           o_state_ena,
    output logic [PE_NUM-1:0]           o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0] o_state_addra,
    input  logic [WORD_WIDTH-1:0]       i_state_dout,
    output logic                        o_amp_valid,
    input  logic                        i_amp_ready,
    output logic [AMP_WIDTH-1:0]        o_amp_data,
    output logic [IDX_WIDTH-1:0]        o_amp_idx,
    output logic                        o_amp_last
);

    state_e                      state_q, state_d;
    logic [STATE_ADDR_WIDTH-1:0] word_q, word_d;
    logic [STATE_ADDR_WIDTH-1:0] last_word_q, last_word_d;
    logic [LAT_WIDTH-1:0]        lat_q, lat_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        ena_q, ena_d;
    logic [STATE_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                        load_c;
    logic                        drained_c;

    // Read sequencing: start, issue read, wait out RAM latency, drain, repeat.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        last_word_d = last_word_q;
        lat_d       = lat_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ena_d       = 1'b0;
        addr_d      = addr_q;
        load_c      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    last_word_d = STATE_ADDR_WIDTH'(word_count(eff_qbit(i_qbit_num))
                                                    - (STATE_ADDR_WIDTH + 1)'(1));
                    word_d      = '0;
                    addr_d      = '0;
                    busy_d      = 1'b1;
                    ena_d       = 1'b1;
                    state_d     = ST_READ;
                end
            end
            ST_READ: begin
                lat_d   = LAT_WIDTH'(RD_LATENCY - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_q == LAT_WIDTH'(0)) begin
                    load_c  = 1'b1;
                    state_d = ST_EMIT;
                end else begin
                    lat_d = lat_q - LAT_WIDTH'(1);
                end
            end
            ST_EMIT: begin
                if (drained_c) begin
                    if (word_q == last_word_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        word_d  = word_q + STATE_ADDR_WIDTH'(1);
                        addr_d  = word_q + STATE_ADDR_WIDTH'(1);
                        ena_d   = 1'b1;
                        state_d = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and RAM-port registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            word_q      <= '0;
            last_word_q <= '0;
            lat_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ena_q       <= 1'b0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            last_word_q <= last_word_d;
            lat_q       <= lat_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ena_q       <= ena_d;
            addr_q      <= addr_d;
        end
    end

    qea_word_serializer u_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (load_c),
        .i_word      (i_state_dout),
        .i_base_idx  ({word_q, PE_NUM_WIDTH'(0)}),
        .i_last_word (word_q == last_word_q),
        .o_amp_valid (o_amp_valid),
        .i_amp_ready (i_amp_ready),
        .o_amp_data  (o_amp_data),
        .o_amp_idx   (o_amp_idx),
        .o_amp_last  (o_amp_last),
        .o_drained_c (drained_c)
    );

    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_state_ena   = {PE_NUM{ena_q}};
    assign o_state_wea   = '0;
    assign o_state_addra = addr_q;

endmodule

// File: tb/tb_qea_state_unloader.sv
// Bench for qea_state_unloader: RAM models at latency 1 and 3, stream monitor, dump model.
module tb_qea_state_unloader;
    import qea_pkg::*;

    typedef struct packed {
        logic [63:0] data;
        logic [17:0] idx;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic [5:0]  qbit = '0;
    logic        i_amp_ready = 1'b1;
    logic        start1 = 1'b0, start3 = 1'b0;

    logic        busy1, done1, valid1, last1, busy3, done3, valid3, last3;
    logic [3:0]  ena1, wea1, ena3, wea3;
    logic [15:0] addr1, addr3;
    logic [255:0] dout1, dout3;
    logic [63:0] data1, data3;
    logic [17:0] idx1, idx3;

    qea_state_unloader #(.RD_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_start(start1), .i_qbit_num(qbit),
        .o_busy(busy1), .o_done(done1), .o_state_ena(ena1), .o_state_wea(wea1),
        .o_state_addra(addr1), .i_state_dout(dout1), .o_amp_valid(valid1),
        .i_amp_ready(i_amp_ready), .o_amp_data(data1), .o_amp_idx(idx1), .o_amp_last(last1));

    qea_state_unloader #(.RD_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .i_start(start3), .i_qbit_num(qbit),
        .o_busy(busy3), .o_done(done3), .o_state_ena(ena3), .o_state_wea(wea3),
        .o_state_addra(addr3), .i_state_dout(dout3), .o_amp_valid(valid3),
        .i_amp_ready(i_amp_ready), .o_amp_data(data3), .o_amp_idx(idx3), .o_amp_last(last3));

    // State RAM contents; read ports return junk on cycles without an enable.
    logic [255:0] mem [0:63];
    localparam logic [255:0] JUNK = {8{32'hDEADBEEF}};
    logic [255:0] pipe3 [0:2];
    always @(posedge clk) dout1 <= (ena1 != 0) ? mem[addr1[5:0]] : JUNK;
    always @(posedge clk) begin
        pipe3[0] <= (ena3 != 0) ? mem[addr3[5:0]] : JUNK;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign dout3 = pipe3[2];

    int checks = 0, errors = 0, cyc = 0;
    beat_t beats0[$], beats1[$], exp_q[$];
    int    addrs0[$], addrs1[$];
    int ena_cnt[2], ena_bad[2], wea_bad[2], overlap_bad[2], stall_bad[2], done_cnt[2];
    int first_ena_cyc[2], done_cyc[2], last_hs_cyc[2];
    logic  prev_valid[2], prev_ready[2];
    beat_t prev_beat[2];

    task automatic clear_mon(input int d);
        if (d == 0) begin beats0.delete(); addrs0.delete(); end
        else begin beats1.delete(); addrs1.delete(); end
        ena_cnt[d] = 0; ena_bad[d] = 0; wea_bad[d] = 0; overlap_bad[d] = 0;
        stall_bad[d] = 0; done_cnt[d] = 0; first_ena_cyc[d] = -1;
        done_cyc[d] = -1; last_hs_cyc[d] = -1;
    endtask

    task automatic mon_sample(input int d, input logic done, input logic [3:0] ena,
                              input logic [3:0] wea, input logic [15:0] addr,
                              input logic valid, input logic [63:0] data,
                              input logic [17:0] idx, input logic last);
        beat_t b;
        b = '{data: data, idx: idx, last: last};
        if (wea != 0) wea_bad[d]++;
        if (ena != 0) begin
            if (ena != 4'hF) ena_bad[d]++;
            if (valid) overlap_bad[d]++;
            if (first_ena_cyc[d] < 0) first_ena_cyc[d] = cyc;
            ena_cnt[d]++;
            if (d == 0) addrs0.push_back(int'(addr)); else addrs1.push_back(int'(addr));
        end
        if (prev_valid[d] && !prev_ready[d] && (!valid || b != prev_beat[d])) stall_bad[d]++;
        if (valid && i_amp_ready) begin
            if (d == 0) beats0.push_back(b); else beats1.push_back(b);
            last_hs_cyc[d] = cyc;
        end
        if (done) begin done_cnt[d]++; done_cyc[d] = cyc; end
        prev_valid[d] = valid;
        prev_ready[d] = i_amp_ready;
        prev_beat[d]  = b;
    endtask

    // Outputs are observed on the falling edge, away from the active edge.
    always @(negedge clk) begin
        cyc++;
        mon_sample(0, done1, ena1, wea1, addr1, valid1, data1, idx1, last1);
        mon_sample(1, done3, ena3, wea3, addr3, valid3, data3, idx3, last3);
    end

    // Reference: amplitude i lives in word i/4, packed MSB-first within the word.
    task automatic build_exp(input logic [5:0] qb);
        int q, n, s;
        logic [255:0] w;
        beat_t b;
        q = (qb < 2) ? 2 : ((qb > 18) ? 18 : int'(qb));
        n = 1 << q;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            w = mem[i / 4];
            s = 3 - (i % 4);
            b.data = w[s*64 +: 64];
            b.idx  = 18'(i);
            b.last = (i == n - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic do_dump(input int d, input logic [5:0] qb, input bit rnd, output bit ok);
        clear_mon(d);
        @(posedge clk); #1;
        qbit = qb; i_amp_ready = 1'b1;
        if (d == 0) start1 = 1'b1; else start3 = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            start1 = 1'b0; start3 = 1'b0;
            i_amp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (done_cnt[d] > 0) begin ok = 1'b1; break; end
        end
        i_amp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy1, done1, ena1, wea1, addr1, valid1, data1, idx1, last1} !== '0) begin
            errors++; $display("FAIL reset_dut1: outputs=%h expected 0",
                {busy1, done1, ena1, wea1, addr1, valid1, data1, idx1, last1});
        end
        checks++;
        if ({busy3, done3, ena3, wea3, addr3, valid3, data3, idx3, last3} !== '0) begin
            errors++; $display("FAIL reset_dut3: outputs nonzero");
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic_dump();
        bit ok;
        foreach (mem[i]) mem[i] = '0;
        mem[0] = {64'h40000000_00000000, 64'h0, 64'h0, 64'h0};
        do_dump(0, 6'd6, 1'b0, ok);
        build_exp(6'd6);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: no o_done"); end
        checks++;
        if (beats0.size() != 64) begin errors++; $display("FAIL basic_count: got %0d want 64", beats0.size()); end
        for (int i = 0; i < exp_q.size() && i < beats0.size(); i++) begin
            checks++;
            if (beats0[i] !== exp_q[i]) begin
                errors++; $display("FAIL basic_beat%0d: got %h want %h", i, beats0[i], exp_q[i]);
            end
        end
        checks++; if (ena_cnt[0] != 16) begin errors++; $display("FAIL basic_ena: got %0d want 16", ena_cnt[0]); end
        checks++;
        if (wea_bad[0] + ena_bad[0] + overlap_bad[0] != 0) begin
            errors++; $display("FAIL basic_port: wea=%0d ena=%0d overlap=%0d want 0", wea_bad[0], ena_bad[0], overlap_bad[0]);
        end
        checks++;
        if (done_cyc[0] != last_hs_cyc[0] + 1 || done_cnt[0] != 1) begin
            errors++; $display("FAIL basic_done: done at %0d (x%0d) want %0d once", done_cyc[0], done_cnt[0], last_hs_cyc[0] + 1);
        end
        checks++;
        if (done_cyc[0] - first_ena_cyc[0] != 96) begin
            errors++; $display("FAIL basic_cycles: got %0d want 96", done_cyc[0] - first_ena_cyc[0]);
        end
        for (int i = 0; i < addrs0.size(); i++) begin
            checks++;
            if (addrs0[i] != i) begin errors++; $display("FAIL basic_addr%0d: got %0d want %0d", i, addrs0[i], i); end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        do_dump(0, 6'd6, 1'b1, ok);
        build_exp(6'd6);
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: no o_done"); end
        checks++;
        if (beats0.size() != 64) begin errors++; $display("FAIL bp_count: got %0d want 64", beats0.size()); end
        for (int i = 0; i < exp_q.size() && i < beats0.size(); i++) begin
            checks++;
            if (beats0[i] !== exp_q[i]) begin
                errors++; $display("FAIL bp_beat%0d: got %h want %h", i, beats0[i], exp_q[i]);
            end
        end
        checks++;
        if (stall_bad[0] != 0) begin errors++; $display("FAIL bp_stable: %0d unstable stalls want 0", stall_bad[0]); end
        checks++;
        if (ena_cnt[0] != 16 || overlap_bad[0] != 0) begin
            errors++; $display("FAIL bp_ena: got %0d overlap %0d want 16/0", ena_cnt[0], overlap_bad[0]);
        end
    endtask

    task automatic test_small_qbit();
        bit ok;
        for (int qb = 1; qb <= 2; qb++) begin
            mem[0] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            mem[1] = JUNK;
            do_dump(0, 6'(qb), 1'b0, ok);
            build_exp(6'(qb));
            checks++;
            if (!ok || beats0.size() != 4) begin
                errors++; $display("FAIL small%0d_count: got %0d done=%0d want 4", qb, beats0.size(), ok);
            end
            for (int i = 0; i < exp_q.size() && i < beats0.size(); i++) begin
                checks++;
                if (beats0[i] !== exp_q[i]) begin
                    errors++; $display("FAIL small%0d_beat%0d: got %h want %h", qb, i, beats0[i], exp_q[i]);
                end
            end
            checks++;
            if (ena_cnt[0] != 1 || addrs0.size() != 1 || addrs0[0] != 0) begin
                errors++; $display("FAIL small%0d_read: ena=%0d want one read at 0", qb, ena_cnt[0]);
            end
        end
    endtask

    task automatic test_start_ignored();
        bit seen;
        clear_mon(0);
        seen = 1'b0;
        @(posedge clk); #1;
        qbit = 6'd3; start1 = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            start1 = (c == 4) || done1;
            if (done1) seen = 1'b1;
            else if (seen) break;
        end
        start1 = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++;
        if (done_cnt[0] != 1) begin errors++; $display("FAIL ignore_done: got %0d dumps want 1", done_cnt[0]); end
        checks++;
        if (beats0.size() != 8 || ena_cnt[0] != 2) begin
            errors++; $display("FAIL ignore_beats: got %0d beats %0d reads want 8/2", beats0.size(), ena_cnt[0]);
        end
        checks++;
        if (busy1 !== 1'b0) begin errors++; $display("FAIL ignore_busy: got %b want 0", busy1); end
    endtask

    task automatic test_reset_mid_dump();
        bit ok, hit;
        for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        clear_mon(0);
        hit = 1'b0;
        @(posedge clk); #1;
        qbit = 6'd6; start1 = 1'b1; i_amp_ready = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (valid1 && idx1 == 18'd22) begin hit = 1'b1; break; end
        end
        checks++; if (!hit) begin errors++; $display("FAIL rst_reach: idx 22 not seen"); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({busy1, done1, ena1, wea1, addr1, valid1, data1, idx1, last1} !== '0) begin
            errors++; $display("FAIL rst_outputs: got %h want 0",
                {busy1, done1, ena1, wea1, addr1, valid1, data1, idx1, last1});
        end
        repeat (10) @(posedge clk);
        #1;
        checks++; if (done_cnt[0] != 0) begin errors++; $display("FAIL rst_nodone: got %0d want 0", done_cnt[0]); end
        do_dump(0, 6'd6, 1'b0, ok);
        build_exp(6'd6);
        checks++;
        if (!ok || beats0.size() != 64) begin errors++; $display("FAIL rst_redump: got %0d beats want 64", beats0.size()); end
        for (int i = 0; i < exp_q.size() && i < beats0.size(); i++) begin
            checks++;
            if (beats0[i] !== exp_q[i]) begin
                errors++; $display("FAIL rst_beat%0d: got %h want %h", i, beats0[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_latency3();
        bit ok;
        for (int i = 0; i < 4; i++)
            for (int s = 0; s < 4; s++)
                mem[i][s*64 +: 64] = {8'(i), 8'(s), 16'h5A5A, $urandom};
        do_dump(1, 6'd4, 1'b0, ok);
        build_exp(6'd4);
        checks++;
        if (!ok || beats1.size() != 16) begin errors++; $display("FAIL lat3_count: got %0d want 16", beats1.size()); end
        for (int i = 0; i < exp_q.size() && i < beats1.size(); i++) begin
            checks++;
            if (beats1[i] !== exp_q[i]) begin
                errors++; $display("FAIL lat3_beat%0d: got %h want %h", i, beats1[i], exp_q[i]);
            end
        end
        checks++;
        if (ena_cnt[1] != 4 || done_cyc[1] - first_ena_cyc[1] != 32) begin
            errors++; $display("FAIL lat3_timing: ena=%0d cycles=%0d want 4/32", ena_cnt[1], done_cyc[1] - first_ena_cyc[1]);
        end
        checks++;
        if (done_cnt[0] != 0) begin errors++; $display("FAIL lat3_isolation: dut1 done %0d want 0", done_cnt[0]); end
    endtask

    initial begin
        clear_mon(0);
        clear_mon(1);
        foreach (mem[i]) mem[i] = '0;
        test_reset();
        test_basic_dump();
        test_backpressure();
        test_small_qbit();
        test_start_ignored();
        test_reset_mid_dump();
        clear_mon(0);
        test_latency3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
